// File: rtl/superscalar_pkg.sv
// Shared definitions for the dual-issue front end: opcodes, field positions, queue entry.
package superscalar_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned REG_W          = 5;
    localparam int unsigned OPC_W          = 6;
    localparam int unsigned QDEPTH_DEFAULT = 4;

    // Register-field slice positions (LSB of each field)
    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RT_LSB  = 16;
    localparam int unsigned RD_LSB  = 11;

    typedef logic [OPC_W-1:0] opcode_t;
    typedef logic [REG_W-1:0] reg_idx_t;

    localparam opcode_t OP_RTYPE = 6'h00;
    localparam opcode_t OP_J     = 6'h02;
    localparam opcode_t OP_BEQ   = 6'h04;
    localparam opcode_t OP_BNE   = 6'h05;
    localparam opcode_t OP_LW    = 6'h23;
    localparam opcode_t OP_SW    = 6'h2B;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } q_entry_t;

    function automatic opcode_t get_opcode(input logic [XLEN-1:0] instr);
        return instr[OPC_LSB +: OPC_W];
    endfunction

    function automatic reg_idx_t get_rs(input logic [XLEN-1:0] instr);
        return instr[RS_LSB +: REG_W];
    endfunction

    function automatic reg_idx_t get_rt(input logic [XLEN-1:0] instr);
        return instr[RT_LSB +: REG_W];
    endfunction

    function automatic reg_idx_t get_rd(input logic [XLEN-1:0] instr);
        return instr[RD_LSB +: REG_W];
    endfunction

endpackage

// File: rtl/dual_issue_unit_if.sv
// Fetch-side and issue-side handshake bundle of the dual-issue unit.
interface dual_issue_unit_if;
    import superscalar_pkg::*;

    logic            fetch_valid;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_instr1;
    logic [XLEN-1:0] fetch_instr2;
    logic            fetch_ready;
    logic            ex_stall;
    logic            flush;
    logic            issue_valid;
    logic [XLEN-1:0] issue_pc;
    logic [XLEN-1:0] decoded1_out;
    logic [XLEN-1:0] decoded2_out;
    logic            issue_dual;

    // Producer of fetch pairs and stall/flush, consumer of issue slots
    modport master (
        output fetch_valid, fetch_pc, fetch_instr1, fetch_instr2, ex_stall, flush,
        input  fetch_ready, issue_valid, issue_pc, decoded1_out, decoded2_out, issue_dual
    );

    // The issue unit itself
    modport slave (
        input  fetch_valid, fetch_pc, fetch_instr1, fetch_instr2, ex_stall, flush,
        output fetch_ready, issue_valid, issue_pc, decoded1_out, decoded2_out, issue_dual
    );

endinterface

// File: rtl/dual_issue_unit_pair_checker.sv
// Decides whether two instructions in program order may issue in the same cycle.
module pair_checker
    import superscalar_pkg::*;
(
    input  logic [XLEN-1:0] instr1_i,
    input  logic [XLEN-1:0] instr2_i,
    output logic            can_dual_o
);

    opcode_t  op1, op2;
    reg_idx_t dst1, dst2, src2a, src2b;
    logic     ctrl1, mem_pair, raw, waw;
    logic     unused_low_c;

    // Immediate/funct bits play no part in the pairing decision
    assign unused_low_c = ^{instr1_i[RD_LSB-1:0], instr2_i[RD_LSB-1:0]};

    assign op1 = get_opcode(instr1_i);
    assign op2 = get_opcode(instr2_i);

    // Destination of slot 1 and slot 2; 0 means no register written
    always_comb begin
        dst1 = get_rt(instr1_i);
        if (op1 == OP_RTYPE) dst1 = get_rd(instr1_i);
        else if (op1 == OP_SW || op1 == OP_BEQ || op1 == OP_BNE || op1 == OP_J) dst1 = '0;
        dst2 = get_rt(instr2_i);
        if (op2 == OP_RTYPE) dst2 = get_rd(instr2_i);
        else if (op2 == OP_SW || op2 == OP_BEQ || op2 == OP_BNE || op2 == OP_J) dst2 = '0;
    end

    // Slot-2 sources; an absent source reads as $0, which never forms a hazard
    always_comb begin
        src2a = '0;
        src2b = '0;
        if (op2 != OP_J) src2a = get_rs(instr2_i);
        if (op2 == OP_RTYPE || op2 == OP_SW || op2 == OP_BEQ || op2 == OP_BNE) src2b = get_rt(instr2_i);
    end

    assign ctrl1    = (op1 == OP_J) || (op1 == OP_BEQ) || (op1 == OP_BNE);
    assign mem_pair = ((op1 == OP_LW) || (op1 == OP_SW)) && ((op2 == OP_LW) || (op2 == OP_SW));
    assign raw      = (dst1 != '0) && ((dst1 == src2a) || (dst1 == src2b));
    assign waw      = (dst1 != '0) && (dst2 != '0) && (dst1 == dst2);

    assign can_dual_o = !ctrl1 && !mem_pair && !raw && !waw;

endmodule

// File: rtl/dual_issue_unit.sv
// Instruction-pair queue feeding the ID/EX register with one or two instructions per cycle.
module dual_issue_unit
    import superscalar_pkg::*;
#(
    parameter int unsigned QDEPTH = QDEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    dual_issue_unit_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    q_entry_t         mem_q [QDEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [PTR_W-1:0] head1_c, tail1_c;
    logic [XLEN-1:0]  slot1_pc_c, slot1_instr_c, slot2_instr_c;
    logic             can_dual_c, ready_c, valid_c, dual_c, push_c;
    logic [1:0]       pop_n_c;

    assign head1_c       = head_q + PTR_W'(1);
    assign tail1_c       = tail_q + PTR_W'(1);
    assign slot1_pc_c    = mem_q[head_q].pc;
    assign slot1_instr_c = mem_q[head_q].instr;
    assign slot2_instr_c = mem_q[head1_c].instr;

    pair_checker u_pair_checker (
        .instr1_i   (slot1_instr_c),
        .instr2_i   (slot2_instr_c),
        .can_dual_o (can_dual_c)
    );

    // Handshake and issue decision from the current occupancy only
    assign ready_c = (count_q <= CNT_W'(QDEPTH - 2));
    assign valid_c = (count_q != '0) && !bus.flush;
    assign dual_c  = valid_c && (count_q >= CNT_W'(2)) && can_dual_c;
    assign push_c  = bus.fetch_valid && ready_c && !bus.flush;
    assign pop_n_c = (valid_c && !bus.ex_stall) ? (dual_c ? 2'd2 : 2'd1) : 2'd0;

    // Next pointers and occupancy; flush discards any same-cycle push and pop
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(pop_n_c);
            tail_d  = push_c ? (tail_q + PTR_W'(2)) : tail_q;
            count_d = count_q + (push_c ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(pop_n_c);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Queue storage; the second word of a pair carries PC+4
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(QDEPTH); i++) mem_q[i] <= '0;
        end else if (push_c) begin
            mem_q[tail_q]  <= '{pc: bus.fetch_pc,            instr: bus.fetch_instr1};
            mem_q[tail1_c] <= '{pc: bus.fetch_pc + 32'd4, instr: bus.fetch_instr2};
        end
    end

    // Issue slots; empty slots present as NOP
    assign bus.fetch_ready  = ready_c;
    assign bus.issue_valid  = valid_c;
    assign bus.issue_dual   = dual_c;
    assign bus.issue_pc     = valid_c ? slot1_pc_c    : '0;
    assign bus.decoded1_out = valid_c ? slot1_instr_c : '0;
    assign bus.decoded2_out = dual_c  ? slot2_instr_c : '0;

endmodule

// File: tb/tb_dual_issue_unit.sv
// Self-checking bench for dual_issue_unit against a queue-based reference model.
module tb_dual_issue_unit;

    localparam int QD = 4;

    logic clk;
    logic reset;

    dual_issue_unit_if bus ();

    dual_issue_unit #(.QDEPTH(QD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t mq[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic        obs_ready, obs_valid, obs_dual;
    logic [31:0] obs_pc, obs_d1, obs_d2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // ---- reference model: pairing rules written directly from the ISA description ----
    function automatic logic [4:0] m_dest(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        case (op)
            6'h00:                      return w[15:11];
            6'h2B, 6'h04, 6'h05, 6'h02: return 5'd0;
            default:                    return w[20:16];
        endcase
    endfunction

    function automatic bit m_reads(input logic [31:0] w, input logic [4:0] r);
        logic [5:0] op;
        op = w[31:26];
        if (r == 5'd0) return 1'b0;
        if (op != 6'h02 && w[25:21] == r) return 1'b1;
        if ((op == 6'h00 || op == 6'h2B || op == 6'h04 || op == 6'h05) && w[20:16] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_is_mem(input logic [31:0] w);
        return (w[31:26] == 6'h23) || (w[31:26] == 6'h2B);
    endfunction

    function automatic bit m_pair(input logic [31:0] a, input logic [31:0] b);
        logic [4:0] d;
        if (a[31:26] == 6'h02 || a[31:26] == 6'h04 || a[31:26] == 6'h05) return 1'b0;
        if (m_is_mem(a) && m_is_mem(b)) return 1'b0;
        d = m_dest(a);
        if (d != 5'd0 && m_reads(b, d)) return 1'b0;
        if (d != 5'd0 && d == m_dest(b)) return 1'b0;
        return 1'b1;
    endfunction

    // ---- instruction builders ----
    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [9];
        logic [5:0] op;
        ops = '{6'h00, 6'h00, 6'h08, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
        op = ops[$urandom_range(0, 8)];
        if (op == 6'h00)
            return rtype($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), 6'h20);
        return itype(op, $urandom_range(0, 5), $urandom_range(0, 5), 16'($urandom));
    endfunction

    // One clock cycle: drive, compare at the falling edge, advance the model
    task automatic step(input bit fv, input logic [31:0] pc, input logic [31:0] i1,
                        input logic [31:0] i2, input bit st, input bit fl);
        bit          e_ready, e_valid, e_dual;
        logic [31:0] e_pc, e_d1, e_d2;
        int          n;
        bus.fetch_valid  = fv;
        bus.fetch_pc     = pc;
        bus.fetch_instr1 = i1;
        bus.fetch_instr2 = i2;
        bus.ex_stall     = st;
        bus.flush        = fl;
        @(negedge clk);
        e_ready = (QD - mq.size()) >= 2;
        e_valid = (mq.size() >= 1) && !fl;
        e_dual  = 1'b0;
        if (e_valid && mq.size() >= 2) e_dual = m_pair(mq[0].instr, mq[1].instr);
        e_pc = 32'h0; e_d1 = 32'h0; e_d2 = 32'h0;
        if (e_valid) begin
            e_pc = mq[0].pc;
            e_d1 = mq[0].instr;
        end
        if (e_dual) e_d2 = mq[1].instr;
        obs_ready = bus.fetch_ready;
        obs_valid = bus.issue_valid;
        obs_dual  = bus.issue_dual;
        obs_pc    = bus.issue_pc;
        obs_d1    = bus.decoded1_out;
        obs_d2    = bus.decoded2_out;
        check("fetch_ready", 64'(obs_ready), 64'(e_ready));
        check("issue_valid", 64'(obs_valid), 64'(e_valid));
        check("issue_dual",  64'(obs_dual),  64'(e_dual));
        check("issue_pc",    64'(obs_pc),    64'(e_pc));
        check("decoded1",    64'(obs_d1),    64'(e_d1));
        check("decoded2",    64'(obs_d2),    64'(e_d2));
        if (fl) begin
            mq.delete();
        end else begin
            n = (e_valid && !st) ? (e_dual ? 2 : 1) : 0;
            repeat (n) void'(mq.pop_front());
            if (fv && e_ready) begin
                mq.push_back('{pc: pc,         instr: i1});
                mq.push_back('{pc: pc + 32'd4, instr: i2});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit st);
        step(1'b0, 32'h0, 32'h0, 32'h0, st, 1'b0);
    endtask

    // Reset pulse placed between clock edges
    task automatic mid_reset();
        bus.fetch_valid = 1'b0;
        bus.ex_stall    = 1'b0;
        bus.flush       = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("arst_valid", 64'(bus.issue_valid),  64'd0);
        check("arst_dual",  64'(bus.issue_dual),   64'd0);
        check("arst_pc",    64'(bus.issue_pc),     64'd0);
        check("arst_d1",    64'(bus.decoded1_out), 64'd0);
        check("arst_ready", 64'(bus.fetch_ready),  64'd1);
        reset = 1'b0;
        mq.delete();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] add_a, sub_b, addi_c, add_d, lw_e, sw_f, beq_g, add_h;
    logic [31:0] rpc;

    initial begin
        bus.fetch_valid  = 1'b0;
        bus.fetch_pc     = 32'h0;
        bus.fetch_instr1 = 32'h0;
        bus.fetch_instr2 = 32'h0;
        bus.ex_stall     = 1'b0;
        bus.flush        = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        add_a  = rtype(1, 2, 3, 6'h20);          // add  $3,$1,$2
        sub_b  = rtype(4, 6, 5, 6'h22);          // sub  $5,$4,$6
        addi_c = itype(6'h08, 0, 2, 16'd1);      // addi $2,$0,1
        add_d  = rtype(2, 3, 4, 6'h20);          // add  $4,$2,$3
        lw_e   = itype(6'h23, 2, 1, 16'd0);      // lw   $1,0($2)
        sw_f   = itype(6'h2B, 4, 3, 16'd4);      // sw   $3,4($4)
        beq_g  = itype(6'h04, 1, 2, 16'd8);      // beq  $1,$2,x
        add_h  = rtype(6, 7, 5, 6'h20);          // add  $5,$6,$7

        // Reset state
        idle(1'b0);
        check("rst_ready", 64'(obs_ready), 64'd1);
        check("rst_valid", 64'(obs_valid), 64'd0);

        // Independent pair issues together one cycle after the push
        step(1'b1, 32'h100, add_a, sub_b, 1'b0, 1'b0);
        idle(1'b0);
        check("dual_ok",  64'(obs_dual), 64'd1);
        check("dual_pc",  64'(obs_pc),   64'h100);
        check("dual_d2",  64'(obs_d2),   64'(sub_b));
        idle(1'b0);
        check("dual_empty", 64'(obs_valid), 64'd0);

        // RAW pair splits into two single issues
        step(1'b1, 32'h200, addi_c, add_d, 1'b0, 1'b0);
        idle(1'b0);
        check("raw_single", 64'(obs_dual), 64'd0);
        check("raw_d2_nop", 64'(obs_d2),   64'd0);
        idle(1'b0);
        check("raw_pc2",    64'(obs_pc),   64'h204);
        check("raw_d1",     64'(obs_d1),   64'(add_d));

        // Two memory ops, then a branch in slot 1
        step(1'b1, 32'h300, lw_e, sw_f, 1'b0, 1'b0);
        idle(1'b0);
        check("mem_single", 64'(obs_dual), 64'd0);
        idle(1'b0);
        step(1'b1, 32'h400, beq_g, add_h, 1'b0, 1'b0);
        idle(1'b0);
        check("br_single", 64'(obs_dual), 64'd0);
        check("br_pc",     64'(obs_pc),   64'h400);
        idle(1'b0);
        idle(1'b0);

        // Stall while filling: queue fills, outputs hold, then drains
        step(1'b1, 32'h500, add_a, sub_b, 1'b1, 1'b0);
        step(1'b1, 32'h508, add_a, sub_b, 1'b1, 1'b0);
        idle(1'b1);
        check("full_ready", 64'(obs_ready), 64'd0);
        check("full_pc",    64'(obs_pc),    64'h500);
        step(1'b1, 32'h510, add_h, add_h, 1'b1, 1'b0);
        check("stall_pc",   64'(obs_pc),    64'h500);
        idle(1'b0);
        check("drain_ready0", 64'(obs_ready), 64'd0);
        idle(1'b0);
        check("drain_ready1", 64'(obs_ready), 64'd1);
        check("drain_pc",     64'(obs_pc),    64'h508);
        idle(1'b0);

        // Flush with a simultaneous push
        step(1'b1, 32'h600, add_a, sub_b, 1'b0, 1'b0);
        step(1'b1, 32'h608, add_a, sub_b, 1'b0, 1'b1);
        check("flush_valid", 64'(obs_valid), 64'd0);
        idle(1'b0);
        check("post_flush_valid", 64'(obs_valid), 64'd0);

        // Asynchronous reset between edges
        step(1'b1, 32'h680, add_a, sub_b, 1'b1, 1'b0);
        mid_reset();
        idle(1'b0);
        check("post_arst_valid", 64'(obs_valid), 64'd0);

        // Back-to-back push and dual issue across pointer wrap
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 32'h700 + 32'(8 * k), add_a, sub_b, 1'b0, 1'b0);
            if (k > 0) check("wrap_pc", 64'(obs_pc), 64'(32'h700 + 32'(8 * (k - 1))));
        end
        idle(1'b0);
        check("wrap_last_pc", 64'(obs_pc), 64'h728);
        idle(1'b0);

        // Randomized traffic against the model
        rpc = 32'h1000;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 59) == 0) begin
                mid_reset();
            end else begin
                step(($urandom_range(0, 3) != 0), rpc, rand_instr(), rand_instr(),
                     ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0));
                rpc = rpc + 32'd8;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
